dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates the pipeline port (P0) and an auxiliary port (P1) onto one data-memory
// port, one access in flight, with a sticky timeout flag. Define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MEM_mem_cmd,
   input  logic [31:0] MEM_mem_addr,
   input  logic [31:0] MEM_mem_din,
   input  logic [1:0]  P1_cmd,
   input  logic [31:0] P1_addr,
   input  logic [31:0] P1_din,
   output logic [31:0] P0_dout,
   output logic        P0_done,
   output logic        P0_stall,
   output logic [31:0] P1_dout,
   output logic        P1_done,
   output logic [1:0]  ARB_mem_cmd,
   output logic [31:0] ARB_mem_addr,
   output logic [31:0] ARB_mem_din,
   input  logic [31:0] DM_mem_dout,
   input  logic        DM_rdy,
   output logic        ARB_err
);

   localparam logic [1:0]        BUS_NONE   = 2'h0;
   localparam logic [1:0]        BUS_LOAD   = 2'h1;
   localparam int unsigned       CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);
   localparam logic [31:0]       ABORT_DATA = 32'hDEADBEEF;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;
   typedef enum logic {PORT0, PORT1} port_t;

   state_t           state_q, state_d;
   port_t            gnt_q, gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             err_q, err_d;
   logic             p0_done_q, p0_done_d, p1_done_q, p1_done_d;
   logic [31:0]      p0_dout_q, p0_dout_d, p1_dout_q, p1_dout_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [31:0]      addr_q, addr_d, din_q, din_d;
`ifdef DMEM_ARB_RR_EN
   port_t            last_q, last_d;
`endif

   logic p0_elig, p1_elig, pick_p1, finish, read_data;

   // A port is not eligible in the cycle its done pulses, so a held command is not re-served.
   assign p0_elig = (MEM_mem_cmd != BUS_NONE) && !p0_done_q;
   assign p1_elig = (P1_cmd != BUS_NONE) && !p1_done_q;
`ifdef DMEM_ARB_RR_EN
   assign pick_p1 = p1_elig && (!p0_elig || (last_q == PORT0));
`else
   assign pick_p1 = p1_elig && !p0_elig;
`endif

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign finish    = DM_rdy || (cnt_inc == CNT_LIMIT);
   assign read_data = (cmd_q == BUS_LOAD);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      p0_done_d = 1'b0;
      p1_done_d = 1'b0;
      p0_dout_d = p0_dout_q;
      p1_dout_d = p1_dout_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      din_d     = din_q;
`ifdef DMEM_ARB_RR_EN
      last_d    = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (p0_elig || p1_elig) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
               gnt_d   = pick_p1 ? PORT1 : PORT0;
               cmd_d   = pick_p1 ? P1_cmd  : MEM_mem_cmd;
               addr_d  = pick_p1 ? P1_addr : MEM_mem_addr;
               din_d   = pick_p1 ? P1_din  : MEM_mem_din;
`ifdef DMEM_ARB_RR_EN
               last_d  = pick_p1 ? PORT1 : PORT0;
`endif
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_inc;
            if (finish) begin
               state_d = S_IDLE;
               if (!DM_rdy) err_d = 1'b1;
               if (gnt_q == PORT1) begin
                  p1_done_d = 1'b1;
                  if (read_data) p1_dout_d = DM_rdy ? DM_mem_dout : ABORT_DATA;
               end else begin
                  p0_done_d = 1'b1;
                  if (read_data) p0_dout_d = DM_rdy ? DM_mem_dout : ABORT_DATA;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= PORT0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         p0_done_q <= 1'b0;
         p1_done_q <= 1'b0;
         p0_dout_q <= '0;
         p1_dout_q <= '0;
         cmd_q     <= BUS_NONE;
         addr_q    <= '0;
         din_q     <= '0;
`ifdef DMEM_ARB_RR_EN
         last_q    <= PORT1;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         p0_done_q <= p0_done_d;
         p1_done_q <= p1_done_d;
         p0_dout_q <= p0_dout_d;
         p1_dout_q <= p1_dout_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
`ifdef DMEM_ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   assign ARB_mem_cmd  = (state_q == S_ACCESS) ? cmd_q : BUS_NONE;
   assign ARB_mem_addr = addr_q;
   assign ARB_mem_din  = din_q;
   assign P0_dout      = p0_dout_q;
   assign P1_dout      = p1_dout_q;
   assign P0_done      = p0_done_q;
   assign P1_done      = p1_done_q;
   assign P0_stall     = (MEM_mem_cmd != BUS_NONE) && !p0_done_q;
   assign ARB_err      = err_q;

endmodule
